// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register interface.
package i2c_pkg;

  // Protocol phases of the target; *_ACK states cover the ninth (acknowledge) bit.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  // Acknowledge bit levels on SDA.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Default depth of the scl/sda input synchronizers.
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Input conditioning for SCL/SDA: synchronizers, optional majority glitch
// filter (enabled by defining I2C_SLV_GLITCH_FILTER_EN), and single-clk
// pulses for SCL edges and START/STOP conditions.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_p0;
  logic                   sda_p0;
  logic                   scl_p1;
  logic                   sda_p1;

  // Synchronizer chains; idle bus level is high, so reset to ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_win;
  logic [1:0] sda_win;

  // Two of three consecutive samples must agree; a 1-clk pulse never wins.
  function automatic logic majority3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

  // Sample history plus registered majority vote (adds 2 clk of latency).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_win <= '1;
      sda_win <= '1;
      scl_p0  <= 1'b1;
      sda_p0  <= 1'b1;
    end else begin
      scl_win <= {scl_win[0], scl_sync[SYNC_STAGES-1]};
      sda_win <= {sda_win[0], sda_sync[SYNC_STAGES-1]};
      scl_p0  <= majority3({scl_win, scl_sync[SYNC_STAGES-1]});
      sda_p0  <= majority3({sda_win, sda_sync[SYNC_STAGES-1]});
    end
  end
`else
  assign scl_p0 = scl_sync[SYNC_STAGES-1];
  assign sda_p0 = sda_sync[SYNC_STAGES-1];
`endif

  // ---- stage p0 -> p1: previous conditioned levels for edge detection ----
  // Hold the previous conditioned level of each line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p1 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p1 <= scl_p0;
      sda_p1 <= sda_p0;
    end
  end

  assign sda_level = sda_p0;
  assign scl_rise  = scl_p0 & ~scl_p1;
  assign scl_fall  = ~scl_p0 & scl_p1;
  assign start_det = scl_p0 & scl_p1 & sda_p1 & ~sda_p0;
  assign stop_det  = scl_p0 & scl_p1 & ~sda_p1 & sda_p0;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target with an 8-bit register pointer and strobe-based register bank
// interface. Optional input glitch filter: define I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       nack_seen
);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ack_phase_q, ack_phase_d;
  logic       sda_low_q, sda_low_d;
  logic       rw_q, rw_d;
  logic       re_pend_q, re_pend_d;
  logic       busy_d;
  logic       we_d;
  logic       re_d;
  logic       nack_d;
  logic       ld_ptr;
  logic       inc_ptr;
  logic       re_dly;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic [7:0] rx_byte;

  logic sda_in;
  logic sda_level;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  // Open-drain output: only ever pull low.
  assign sda    = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in = sda;

  i2c_bus_monitor #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_monitor (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Byte as it stands including the bit being sampled this clk.
  assign rx_byte = {rx_q[6:0], sda_level};

  // Next-state and control decode; STOP beats START beats normal bit flow.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ack_phase_d = ack_phase_q;
    sda_low_d   = sda_low_q;
    rw_d        = rw_q;
    busy_d      = busy;
    re_pend_d   = 1'b0;
    we_d        = 1'b0;
    re_d        = re_pend_q;
    nack_d      = 1'b0;
    ld_ptr      = 1'b0;
    inc_ptr     = 1'b0;

    if (stop_det) begin
      state_d     = ST_IDLE;
      sda_low_d   = 1'b0;
      ack_phase_d = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd7;
      sda_low_d   = 1'b0;
      ack_phase_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sda_low_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (state_q == ST_REG) begin
                ld_ptr  = 1'b1;
                state_d = ST_REG_ACK;
              end else begin
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              // First fall opens the ACK slot: pull SDA low and issue the access.
              ack_phase_d = 1'b1;
              sda_low_d   = 1'b1;
              if (state_q == ST_ADDR_ACK && rw_q) re_d = 1'b1;
              if (state_q == ST_WDATA_ACK) we_d = 1'b1;
            end else begin
              // Second fall closes the slot; a read starts driving its MSB here.
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd7;
              sda_low_d   = 1'b0;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  state_d   = ST_RDATA;
                  sda_low_d = ~tx_q[7];
                end else begin
                  state_d = ST_REG;
                end
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_fall) sda_low_d = ~tx_q[bit_cnt_q];
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) state_d = ST_RDATA_ACK;
            else                   bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end

        ST_RDATA_ACK: begin
          if (scl_fall) sda_low_d = 1'b0;
          if (scl_rise) begin
            if (sda_level == ACK) begin
              // Advance the pointer first so the read request sees the new address.
              inc_ptr   = 1'b1;
              re_pend_d = 1'b1;
              bit_cnt_d = 3'd7;
              state_d   = ST_RDATA;
            end else begin
              nack_d  = 1'b1;
              state_d = ST_IGNORE;
            end
          end
        end

        ST_IGNORE: begin
          sda_low_d = 1'b0;
        end

        default: begin
          state_d   = ST_IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  // Control registers and register-bank strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd7;
      ack_phase_q <= 1'b0;
      sda_low_q   <= 1'b0;
      rw_q        <= 1'b0;
      re_pend_q   <= 1'b0;
      re_dly      <= 1'b0;
      busy        <= 1'b0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      nack_seen   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_phase_q <= ack_phase_d;
      sda_low_q   <= sda_low_d;
      rw_q        <= rw_d;
      re_pend_q   <= re_pend_d;
      re_dly      <= reg_re;
      busy        <= busy_d;
      reg_we      <= we_d;
      reg_re      <= re_d;
      nack_seen   <= nack_d;
    end
  end

  // Register pointer and write data; the pointer auto-increments after each access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
    end else begin
      if (ld_ptr)                 reg_addr <= rx_byte;
      else if (reg_we || inc_ptr) reg_addr <= reg_addr + 8'd1;
      if (we_d) reg_wdata <= rx_q;
    end
  end

  // Receive shifter (MSB first) and transmit byte latched the clk after reg_re.
  always_ff @(posedge clk) begin
    if (scl_rise) rx_q <= rx_byte;
    if (re_dly)   tx_q <= reg_rdata;
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-level I2C master, register-strobe scoreboard.
module tb_i2c_slave_regif;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h3C;
  logic       busy;
  logic       nack_seen;
  wire        sda;

  int checks = 0;
  int failures = 0;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_regif dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (m_scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  localparam logic [1:0] EV_WE = 2'd1, EV_RE = 2'd2, EV_NACK = 2'd3;
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe the DUT presents is matched against the next expected event.
  always @(negedge clk) begin
    ev_t got;
    ev_t e;
    if (!reset && (reg_we || reg_re || nack_seen)) begin
      got.kind = reg_we ? EV_WE : (reg_re ? EV_RE : EV_NACK);
      got.addr = (reg_we || reg_re) ? reg_addr : 8'h00;
      got.data = reg_we ? reg_wdata : 8'h00;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got kind=%0d addr=%h data=%h expected none",
                 got.kind, got.addr, got.data);
      end else begin
        e = exp_q.pop_front();
        check("strobe_event", 32'(got), 32'(e));
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_sda_low = ~b;
    if (glitch) begin
      repeat (Q / 2) @(negedge clk);
      m_scl = 1'b1;
      @(negedge clk);
      m_scl = 1'b0;
      repeat (Q - Q / 2 - 1) @(negedge clk);
    end else begin
      wait_q();
    end
    m_scl = 1'b1;
    wait_q();
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    b = sda;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda_low = 1'b1;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda_low = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      b[i] = bit_v;
    end
    write_bit(master_ack, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'h00);
    check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'h00);
    check({tag, "_reg_we"}, 32'(reg_we), 32'h0);
    check({tag, "_reg_re"}, 32'(reg_re), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_nack_seen"}, 32'(nack_seen), 32'h0);
    check({tag, "_sda_released"}, 32'(sda), 32'h1);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Simple single-byte register write.
    expect_ev(EV_WE, 8'h12, 8'h5A);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("t1_addr_ack", 32'(ack), 32'h0);
    check("t1_busy_after_match", 32'(busy), 32'h1);
    write_byte(8'h12, -1, ack); check("t1_reg_ack", 32'(ack), 32'h0);
    write_byte(8'h5A, -1, ack); check("t1_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t1_busy_after_stop", 32'(busy), 32'h0);

    // Pointer write, repeated START, single-byte read ended by NACK.
    expect_ev(EV_RE, 8'h12, 8'h00);
    expect_ev(EV_NACK, 8'h00, 8'h00);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("t2_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h12, -1, ack); check("t2_reg_ack", 32'(ack), 32'h0);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("t2_raddr_ack", 32'(ack), 32'h0);
    read_byte(1'b1, rb);
    check("t2_read_byte", 32'(rb), 32'h3C);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t2_sda_released", 32'(sda), 32'h1);
    check("t2_busy_after_stop", 32'(busy), 32'h0);

    // Two data bytes across the pointer wrap.
    expect_ev(EV_WE, 8'hFF, 8'h11);
    expect_ev(EV_WE, 8'h00, 8'h22);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("t3_addr_ack", 32'(ack), 32'h0);
    write_byte(8'hFF, -1, ack); check("t3_reg_ack", 32'(ack), 32'h0);
    write_byte(8'h11, -1, ack); check("t3_data0_ack", 32'(ack), 32'h0);
    write_byte(8'h22, -1, ack); check("t3_data1_ack", 32'(ack), 32'h0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t3_ptr_after_wrap", 32'(reg_addr), 32'h01);

    // Foreign address: never acknowledged, no strobes, never busy.
    i2c_start();
    write_byte(8'hA2, -1, ack); check("t4_addr_nack", 32'(ack), 32'h1);
    check("t4_busy_stays_low", 32'(busy), 32'h0);
    write_byte(8'h12, -1, ack); check("t4_byte_nack", 32'(ack), 32'h1);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t4_busy_after_stop", 32'(busy), 32'h0);

    // Reset while the target is acknowledging the pointer byte.
    i2c_start();
    write_byte(8'hA0, -1, ack); check("t5_addr_ack", 32'(ack), 32'h0);
    for (int i = 7; i >= 0; i--) write_bit(logic'((8'h44 >> i) & 8'h01), 1'b0);
    m_sda_low = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    check("t5_reg_ack_driven", 32'(sda), 32'h0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    expect_ev(EV_WE, 8'h05, 8'h77);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("t5_post_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h05, -1, ack); check("t5_post_reg_ack", 32'(ack), 32'h0);
    write_byte(8'h77, -1, ack); check("t5_post_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    repeat (4) @(negedge clk);

`ifdef I2C_SLV_GLITCH_FILTER_EN
    // One-clk SCL glitches while SCL is low must not shift extra bits.
    expect_ev(EV_WE, 8'h30, 8'hC3);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("t6_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h30, 4, ack);  check("t6_reg_ack", 32'(ack), 32'h0);
    write_byte(8'hC3, 1, ack);  check("t6_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    repeat (4) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    check("all_expected_strobes_seen", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
Clock-oversampled I2C target (slave) that responds to the team's I2C master on the same SCL/SDA pair. It decodes a 7-bit device address, an 8-bit register pointer and write data, and answers reads after a repeated START. Register accesses appear on a simple strobe interface (reg_addr, reg_wdata, reg_we, reg_re, reg_rdata) that connects to a local register bank. clk must be at least 20x the SCL frequency.

Parameters:
DEV_ADDR, 7'h50, 7-bit device address this target acknowledges
SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronizers (minimum 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
scl  in  1  I2C clock from the master
sda  inout  1  open-drain data; driven only as 1'b0, otherwise 1'bz
reg_addr  out  8  register pointer
reg_wdata  out  8  write data byte
reg_we  out  1  one-clk write strobe
reg_re  out  1  one-clk read request
reg_rdata  in  8  read data; must be valid on the clk after reg_re
busy  out  1  high from an address match until STOP
nack_seen  out  1  one-clk pulse when the master NACKs a read byte

Behaviour:
- Reset (asynchronous, active-high) values: sda released; reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, nack_seen=0; state IDLE.
- Inputs pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized values:
  - START = sda falls while scl is high.
  - STOP = sda rises while scl is high.
  - SCL rise / SCL fall = single-clk pulses.
- Bits are sampled on SCL rise and the shift register is MSB first. The sda drive is changed only on SCL fall.
- A 3-bit bit counter runs 7..0. A byte completes when the counter reaches 0 at an SCL rise.
- States:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits.
    - addr[7:1]==DEV_ADDR with R/W=0: go to ADDR_ACK(W).
    - Match with R/W=1: go to ADDR_ACK(R).
    - Mismatch: go to IGNORE with sda never driven.
  - ADDR_ACK: drive sda=0 from the next SCL fall until the following SCL fall.
    - Write: then go to REG.
    - Read: assert reg_re at the SCL fall that starts the ACK slot, latch reg_rdata one clk later, then go to RDATA.
  - REG: shift 8 bits, load reg_addr, then go to REG_ACK.
  - REG_ACK: ACK as above, then go to WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK. At the SCL fall starting the ACK slot, pulse reg_we for 1 clk with reg_wdata=byte and reg_addr=pointer.
  - WDATA_ACK: ACK; reg_addr increments (8-bit wrap 8'hFF->8'h00) one clk after reg_we; then return to WDATA.
  - RDATA: drive each bit on SCL fall (sda=0 for 0, released for 1). After 8 bits, release sda and go to RDATA_ACK.
  - RDATA_ACK: sample the master bit on SCL rise.
    - 0 (ACK): increment reg_addr, pulse reg_re, reload, go to RDATA.
    - 1 (NACK): pulse nack_seen, go to IGNORE.
  - IGNORE: sda released; wait for START or STOP.
- START in any state (repeated START) goes to ADDR. reg_addr is kept, so the write-pointer-then-read sequence works.
- STOP in any state goes to IDLE and releases sda. STOP takes priority if both are flagged in one clk (cannot legally happen).
- busy is set on the address-match ACK and cleared on STOP or reset.
- Reset mid-transfer releases sda within the same cycle (asynchronous clear). The next transfer requires a fresh START.
- Bytes of the write sequence fragment cut short by STOP produce no reg_we.

Optional Feature:
I2C_SLV_GLITCH_FILTER_EN
- Defined: add a 3-sample majority filter on the synchronized scl/sda before edge detection, which rejects pulses of 1 clk or shorter. Latency is +2 clk.
- Undefined: raw synchronized signals are used.

Decomposition:
- Package i2c_pkg:
  - state enum
  - ACK=1'b0, NACK=1'b1
  - default SYNC_STAGES
- Sub-module i2c_bus_monitor: synchronizers, optional glitch filter, and scl_rise, scl_fall, start_det, stop_det pulse outputs.

Test Plan:
- Write 24'hA0_12_5A then STOP -> ACK in all 3 slots; one reg_we with reg_addr=8'h12, reg_wdata=8'h5A; busy falls at STOP.
- Write A0,12 / repeated START / A1 with reg_rdata=8'h3C, master NACKs -> reg_re once; SDA bits 0,0,1,1,1,1,0,0; nack_seen pulses; sda released.
- Write A0,FF,11,22 -> reg_we at 8'hFF (data 11) then at 8'h00 (data 22), confirming pointer wrap.
- Address byte A2 -> sda never driven low; no reg_we/reg_re; busy stays 0 through STOP.
- Reset asserted mid-REG byte -> sda=z immediately; outputs at reset values; next A0,05,77 transfer succeeds.
- With I2C_SLV_GLITCH_FILTER_EN, inject a 1-clk SCL high glitch while SCL is low -> no bit shifted; the transfer completes correctly.
